lane_judge_scorer: RTL

Parametrised successor to the fixed 4-lane ROM block manager's note/hit logic. Holds a falling-note field of NUM_LANES x ROWS and shifts it down one row on each tick. Judges key presses per lane as PERFECT or GOOD, detects misses, and maintains score, combo and max combo. Sits between clock_divider/chart source (tick, spawn) and led_matrix_driver/ScanDisplayDriver (frame, score).

---
 rtl/lane_judge_scorer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lane_judge_scorer.sv
// Falling-note lane field with per-lane PERFECT/GOOD/MISS judging, score, combo and max combo.
// Optional `COMBO_BONUS_EN: doubles the points of a cycle while the pre-update combo is 10 or more.
module lane_judge_scorer #(
  parameter int NUM_LANES   = 4,
  parameter int ROWS        = 16,
  parameter int HIT_WIN     = 3,
  parameter int PTS_PERFECT = 2,
  parameter int PTS_GOOD    = 1,
  parameter int SCORE_W     = 32,
  parameter int COMBO_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      pause,
  input  logic [NUM_LANES-1:0]      spawn,
  input  logic [NUM_LANES-1:0]      hit_key,
  output logic [NUM_LANES*ROWS-1:0] frame,
  output logic [SCORE_W-1:0]        score,
  output logic [COMBO_W-1:0]        combo,
  output logic [COMBO_W-1:0]        max_combo,
  output logic [NUM_LANES-1:0]      perfect_pulse,
  output logic [NUM_LANES-1:0]      good_pulse,
  output logic [NUM_LANES-1:0]      miss_pulse
);

  localparam int PTS_MAX = (PTS_PERFECT > PTS_GOOD) ? PTS_PERFECT : PTS_GOOD;
`ifdef COMBO_BONUS_EN
  localparam int BONUS_MUL = 2;
`else
  localparam int BONUS_MUL = 1;
`endif
  localparam int PTS_W   = $clog2(NUM_LANES * PTS_MAX * BONUS_MUL + 1);
  localparam int CNT_W   = $clog2(NUM_LANES + 1);
  localparam int SSUM_W  = SCORE_W + 1;
  localparam int CSUM_W  = COMBO_W + 1;

  // Packed lane-major field: bit lane*ROWS+row maps straight onto frame.
  logic [NUM_LANES-1:0][ROWS-1:0] field_q, field_d;
  logic [NUM_LANES-1:0]           key_prev_q;
  logic [NUM_LANES-1:0]           press, tick_v;
  logic [NUM_LANES-1:0]           perfect_d, good_d, miss_d;
  logic [NUM_LANES-1:0]           perfect_q, good_q, miss_q;
  logic [PTS_W-1:0]               pts_add;
  logic [CNT_W-1:0]               hit_cnt;
  logic [SSUM_W-1:0]              score_sum;
  logic [CSUM_W-1:0]              combo_sum;
  logic [SCORE_W-1:0]             score_q, score_d;
  logic [COMBO_W-1:0]             combo_q, combo_d;
  logic [COMBO_W-1:0]             max_q, max_d;

  // Pause swallows presses and ticks, which also forces all pulses and point adds to zero.
  assign press  = hit_key & ~key_prev_q & {NUM_LANES{~pause}};
  assign tick_v = {NUM_LANES{tick & ~pause}};

  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    field_d   = field_q;
    perfect_d = '0;
    good_d    = '0;
    miss_d    = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      // Judge on the pre-shift field, lowest occupied zone row wins.
      if (press[l]) begin
        for (int k = 0; k < HIT_WIN; k++) begin
          if (!(perfect_d[l] || good_d[l]) && field_d[l][ROWS-1-k]) begin
            field_d[l][ROWS-1-k] = 1'b0;
            if (k == 0) perfect_d[l] = 1'b1;
            else        good_d[l]    = 1'b1;
          end
        end
      end
      if (tick_v[l]) begin
        miss_d[l]  = field_d[l][ROWS-1];
        field_d[l] = {field_d[l][ROWS-2:0], spawn[l]};
      end
    end
  end

  always_comb begin
    pts_add = '0;
    hit_cnt = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (perfect_d[l]) pts_add = pts_add + PTS_W'(PTS_PERFECT);
      if (good_d[l])    pts_add = pts_add + PTS_W'(PTS_GOOD);
      hit_cnt = hit_cnt + CNT_W'(perfect_d[l] | good_d[l]);
    end
`ifdef COMBO_BONUS_EN
    if (combo_q >= COMBO_W'(10)) pts_add = pts_add << 1;
`endif
    score_sum = {1'b0, score_q} + SSUM_W'(pts_add);
    score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    combo_sum = {1'b0, combo_q} + CSUM_W'(hit_cnt);
    if (|miss_d)                combo_d = '0;
    else if (combo_sum[COMBO_W]) combo_d = '1;
    else                        combo_d = combo_sum[COMBO_W-1:0];

    max_d = (combo_d > max_q) ? combo_d : max_q;
  end

  // key_prev resets to all ones so a key held through reset never registers as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_q    <= '0;
      key_prev_q <= '1;
      score_q    <= '0;
      combo_q    <= '0;
      max_q      <= '0;
      perfect_q  <= '0;
      good_q     <= '0;
      miss_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      field_q    <= field_d;
      key_prev_q <= hit_key;
      score_q    <= score_d;
      combo_q    <= combo_d;
      max_q      <= max_d;
      perfect_q  <= perfect_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
    end
  end

  assign frame         = field_q;
  assign score         = score_q;
  assign combo         = combo_q;
  assign max_combo     = max_q;
  assign perfect_pulse = perfect_q;
  assign good_pulse    = good_q;
  assign miss_pulse    = miss_q;

endmodule
